// File: rtl/fpa_align_scheduler.sv
// Round-robin scheduler sharing one FP alignment datapath between two requesters (issue + result stage).
// Optional saturating statistics counters are built when FPA_ALIGN_SCHED_STATS_EN is defined.
module fpa_align_scheduler #(
   parameter int TAGW = 4,
   parameter int OPW  = 78
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OPW-1:0]  req0_ops,
   input  logic [TAGW-1:0] req0_tag,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OPW-1:0]  req1_ops,
   input  logic [TAGW-1:0] req1_tag,
   output logic [7:0]      dp_exp_a,
   output logic [7:0]      dp_exp_b,
   output logic [27:0]     dp_mantis_a,
   output logic [27:0]     dp_mantis_b,
   output logic [2:0]      dp_type_a,
   output logic [2:0]      dp_type_b,
   input  logic [7:0]      dp_exp,
   input  logic [27:0]     dp_mantis_great,
   input  logic [27:0]     dp_mantis_small,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_exp,
   output logic [27:0]     out_great,
   output logic [27:0]     out_small,
   output logic            out_src,
   output logic [TAGW-1:0] out_tag
`ifdef FPA_ALIGN_SCHED_STATS_EN
   ,
   output logic [15:0]     stat_grant0,
   output logic [15:0]     stat_grant1,
   output logic [15:0]     stat_stall
`endif
);

   logic            s1_valid_r;
   logic [OPW-1:0]  s1_ops_r;
   logic [TAGW-1:0] s1_tag_r;
   logic            s1_src_r;
   logic            last_grant_r;

   logic            out_valid_r;
   logic [7:0]      out_exp_r;
   logic [27:0]     out_great_r;
   logic [27:0]     out_small_r;
   logic            out_src_r;
   logic [TAGW-1:0] out_tag_r;

   logic            drain_s;
   logic            s2_load_s;
   logic            s1_load_s;
   logic            grant_any_s;
   logic            grant_s;
   logic            hs_s;
   logic            hs0_s;
   logic            hs1_s;
   logic [OPW-1:0]  sel_ops_s;
   logic [TAGW-1:0] sel_tag_s;

   // Stage-advance conditions: a draining result register lets the issue stage move in the same cycle.
   always_comb begin
      drain_s   = out_valid_r & out_ready;
      s2_load_s = s1_valid_r & (~out_valid_r | drain_s);
      s1_load_s = ~s1_valid_r | s2_load_s;
   end

   // Round-robin pick; on a tie the requester that did not win last time gets the slot.
   always_comb begin
      grant_any_s = 1'b0;
      grant_s     = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_any_s = 1'b1;
         grant_s     = ~last_grant_r;
      end else if (req0_valid) begin
         grant_any_s = 1'b1;
         grant_s     = 1'b0;
      end else if (req1_valid) begin
         grant_any_s = 1'b1;
         grant_s     = 1'b1;
      end else begin
         grant_any_s = 1'b0;
         grant_s     = 1'b0;
      end
   end

   // Handshake qualification and the operand/tag mux feeding the issue register.
   always_comb begin
      hs_s  = grant_any_s & s1_load_s & ~rst;
      hs0_s = hs_s & ~grant_s;
      hs1_s = hs_s & grant_s;
      if (grant_s) begin
         sel_ops_s = req1_ops;
         sel_tag_s = req1_tag;
      end else begin
         sel_ops_s = req0_ops;
         sel_tag_s = req0_tag;
      end
   end

   // Issue register: holds the granted operation while the shared datapath works on it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r   <= 1'b0;
         s1_ops_r     <= {OPW{1'b0}};
         s1_tag_r     <= {TAGW{1'b0}};
         s1_src_r     <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         if (hs_s) begin
            s1_ops_r     <= sel_ops_s;
            s1_tag_r     <= sel_tag_s;
            s1_src_r     <= grant_s;
            last_grant_r <= grant_s;
         end
         s1_valid_r <= hs_s | (s1_valid_r & ~s2_load_s);
      end
   end

   // Result register: captures the datapath outputs plus the issue-stage bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_exp_r   <= 8'd0;
         out_great_r <= 28'd0;
         out_small_r <= 28'd0;
         out_src_r   <= 1'b0;
         out_tag_r   <= {TAGW{1'b0}};
      end else begin
         if (s2_load_s) begin
            out_exp_r   <= dp_exp;
            out_great_r <= dp_mantis_great;
            out_small_r <= dp_mantis_small;
            out_src_r   <= s1_src_r;
            out_tag_r   <= s1_tag_r;
         end
         out_valid_r <= s2_load_s | (out_valid_r & ~drain_s);
      end
   end

   assign req0_ready  = hs0_s;
   assign req1_ready  = hs1_s;
   assign dp_exp_a    = s1_ops_r[7:0];
   assign dp_exp_b    = s1_ops_r[15:8];
   assign dp_mantis_a = s1_ops_r[43:16];
   assign dp_mantis_b = s1_ops_r[71:44];
   assign dp_type_a   = s1_ops_r[74:72];
   assign dp_type_b   = s1_ops_r[77:75];
   assign out_valid   = out_valid_r;
   assign out_exp     = out_exp_r;
   assign out_great   = out_great_r;
   assign out_small   = out_small_r;
   assign out_src     = out_src_r;
   assign out_tag     = out_tag_r;

`ifdef FPA_ALIGN_SCHED_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
      logic [15:0] res;
      if (en && (val != 16'hFFFF)) begin
         res = val + 16'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

   logic [15:0] stat_grant0_r;
   logic [15:0] stat_grant1_r;
   logic [15:0] stat_stall_r;

   // Saturating per-requester handshake counters and downstream stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant0_r <= 16'd0;
         stat_grant1_r <= 16'd0;
         stat_stall_r  <= 16'd0;
      end else begin
         stat_grant0_r <= sat_inc16(stat_grant0_r, hs0_s);
         stat_grant1_r <= sat_inc16(stat_grant1_r, hs1_s);
         stat_stall_r  <= sat_inc16(stat_stall_r, out_valid_r & ~out_ready);
      end
   end

   assign stat_grant0 = stat_grant0_r;
   assign stat_grant1 = stat_grant1_r;
   assign stat_stall  = stat_stall_r;
`endif

endmodule
